frame_update_scheduler: RTL
===========================

// Module: frame_update_scheduler
// PURPOSE
//  Sequences per-frame game-state updates (paddle, ball, bricks, ...) into vertical blanking.
//  Watches vcounter from the VGA timing block and issues one-at-a-time req/ack handshakes.
//  Serves clients in fixed index order so updates never tear the visible picture.
//  Flags timeouts, lateness and frame overruns.
// PARAMETERS
//  V_VISIBLE  480  first vcounter value of vertical blanking (visible lines are 0..V_VISIBLE-1)
//  N_CLIENTS  3    number of update clients (1..8)
//  TIMEOUT    1024 max cycles req[i] stays high without ack before the client is abandoned
// PORTS
//  CLK           in   1          system/pixel clock; all logic on posedge
//  reset         in   1          synchronous, active-high; one clock clears all state
//  vcounter      in   11         line counter from VGA timing block
//  enable        in   N_CLIENTS  client participation mask, sampled once per frame
//  ack           in   N_CLIENTS  client i asserts ack[i] when its update is complete
//  req           out  N_CLIENTS  one-hot-or-zero request to client i
//  busy          out  1          sequence in progress
//  frame_tick    out  1          1-cycle pulse at start of vblank
//  timeout_flags out  N_CLIENTS  bit i set if client i timed out this frame
//  late          out  1          1-cycle pulse: sequence still busy when visible area restarts
//  overrun       out  1          1-cycle pulse: frame_tick arrived while busy
//  frame_cnt     out  16         frames started; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: req=0, busy=0, frame_tick=0, timeout_flags=0, late=0, overrun=0, frame_cnt=0.
//  Reset also sets: state=IDLE, idx=0, vb_q=1 (no spurious tick when reset occurs inside vblank).
//  vb = (vcounter >= V_VISIBLE); vb_q <= vb each cycle.
//  frame_tick <= vb & ~vb_q; it is high the cycle after the first edge at which vb=1 is sampled.
//  late <= ~vb & vb_q & busy (vblank->visible transition while busy). late does not abort the sequence.
//  FSM states IDLE, SELECT, REQ:
//   IDLE: on frame_tick -> SELECT with the following actions:
//     - latch en_q<=enable, idx<=0, clear timeout_flags
//     - frame_cnt+=1, busy<=1
//   SELECT (1 cycle): if some k>=idx has en_q[k]=1, idx<=lowest such k and -> REQ;
//     otherwise busy<=0 and -> IDLE.
//   REQ: req[idx]=1 (registered, rises the cycle after entry); timer counts from 0.
//     - ack[idx]=1 sampled: req<=0 next cycle, idx<=idx+1, -> SELECT.
//     - timer reaches TIMEOUT-1 without ack: timeout_flags[idx]<=1, req<=0, idx+1, -> SELECT.
//     - ack and timeout on the same cycle: treated as ack; no flag.
//  ack bits for non-requested clients are ignored. ack held high across transitions does not double-count.
//    Each REQ entry requires a fresh sample, and req for the next client is only granted via SELECT.
//  frame_tick while state!=IDLE: overrun<=1 for one cycle; tick otherwise ignored.
//    On an overrun, frame_cnt is not incremented and the sequence continues.
//  Minimum handshake: req high >=1 cycle; ack may be same-cycle combinational or later.
//  enable changes mid-sequence have no effect until the next frame_tick.
//  en_q=0: each frame still ticks: IDLE->SELECT->IDLE, with busy high for exactly 1 cycle.
//  timer width = clog2(TIMEOUT); idx width = clog2(N_CLIENTS)+1, so idx==N_CLIENTS terminates SELECT.
//  Reset mid-REQ: req drops on the reset edge; no flag set; next tick starts a fresh sequence.
// TESTING (N_CLIENTS=3, TIMEOUT=16, V_VISIBLE=480)
//  1. Nominal frame:
//     - stimulus: vcounter 479->480; enable=3'b111; each client acks 3 cycles after its req
//     - response: frame_tick 1 cycle; req=001,010,100 in turn; busy falls; frame_cnt=1; flags=0
//  2. Masked client:
//     - stimulus: enable=3'b101
//     - response: req[1] never asserts; req goes 001 then 100
//  3. Timeout:
//     - stimulus: client 1 never acks
//     - response: req[1] high exactly 16 cycles; timeout_flags=3'b010; client 2 still served
//  4. Late and overrun:
//     - stimulus: client 0 never acks with TIMEOUT large; vcounter passes 524->0 and back to 480
//     - response: late pulse once at wrap; overrun pulse at the next tick; frame_cnt unchanged
//  5. Reset behaviour:
//     - stimulus a: reset while vcounter=500 -> no frame_tick until after vcounter<480 and then >=480
//     - stimulus b: reset mid-REQ -> all outputs zero the next cycle
//  6. Ack edge cases:
//     - stimulus: ack[2] pulsed during req[0]; ack held high for the whole sequence
//     - response: spurious ack is ignored; with held ack each client gets exactly one req cycle

Source files
------------

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
// Sequences per-frame game-state updates into vertical blanking. Each frame
// start (first vblank line) latches the client enable mask, then serves the
// enabled clients one at a time, in ascending index order, with a req/ack
// handshake. Clients that do not answer within TIMEOUT cycles are abandoned
// and flagged. The late and overrun pulses report a sequence that spilled
// into the visible area or into the next frame.

module frame_update_scheduler #(
  parameter int V_VISIBLE = 480,
  parameter int N_CLIENTS = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [10:0]          vcounter,
  input  logic [N_CLIENTS-1:0] enable,
  input  logic [N_CLIENTS-1:0] ack,
  output logic [N_CLIENTS-1:0] req,
  output logic                 busy,
  output logic                 frame_tick,
  output logic [N_CLIENTS-1:0] timeout_flags,
  output logic                 late,
  output logic                 overrun,
  output logic [15:0]          frame_cnt
);

  // idx carries one extra bit so that idx == N_CLIENTS ends the sequence.
  localparam int IDX_W = $clog2(N_CLIENTS) + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [10:0]      VB_START = 11'(V_VISIBLE);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    REQ
  } state_t;

  // Registered state
  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [N_CLIENTS-1:0]   en_q;
  logic [TMR_W-1:0]       timer;
  logic                   vb_q;

  // Next-state values from the FSM process
  state_t                 state_n;
  logic [IDX_W-1:0]       idx_n;
  logic [N_CLIENTS-1:0]   en_q_n;
  logic [TMR_W-1:0]       timer_n;
  logic [N_CLIENTS-1:0]   req_n;
  logic                   busy_n;
  logic [N_CLIENTS-1:0]   flags_n;
  logic                   overrun_n;
  logic [15:0]            frame_cnt_n;

  // Helpers
  logic                   vb;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [N_CLIENTS-1:0]   sel_onehot;
  logic [N_CLIENTS-1:0]   idx_onehot;
  logic                   ack_sel;

  assign vb = (vcounter >= VB_START);

  // Find the lowest enabled client at or above idx, and one-hot decode idx.
  // NOTE: every always_comb output gets a default before any branch, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    idx_onehot = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      if (en_q[k] && (IDX_W'(k) >= idx)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      sel_onehot[i] = (sel_idx == IDX_W'(i));
      idx_onehot[i] = (idx == IDX_W'(i));
    end
  end

  // Only the acknowledge of the client currently being served matters.
  assign ack_sel = |(ack & idx_onehot);

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    en_q_n      = en_q;
    timer_n     = timer;
    req_n       = req;
    busy_n      = busy;
    flags_n     = timeout_flags;
    frame_cnt_n = frame_cnt;
    overrun_n   = 1'b0;

    // A frame start while a sequence is still running is reported and dropped.
    if (frame_tick && (state != IDLE)) begin
      overrun_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_n     = SELECT;
          en_q_n      = enable;
          idx_n       = '0;
          flags_n     = '0;
          frame_cnt_n = frame_cnt + 16'd1;
          busy_n      = 1'b1;
        end
      end

      SELECT: begin
        if (sel_found) begin
          state_n = REQ;
          idx_n   = sel_idx;
          timer_n = '0;
          req_n   = sel_onehot;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end

      REQ: begin
        // Ack wins over a timeout expiring on the same cycle.
        if (ack_sel) begin
          state_n = SELECT;
          req_n   = '0;
          idx_n   = idx + IDX_ONE;
        end else if (timer == TMR_LAST) begin
          state_n = SELECT;
          req_n   = '0;
          idx_n   = idx + IDX_ONE;
          flags_n = timeout_flags | idx_onehot;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register, vblank edge detection and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      en_q          <= '0;
      timer         <= '0;
      // Starting at 1 suppresses a tick when reset releases inside vblank.
      vb_q          <= 1'b1;
      req           <= '0;
      busy          <= 1'b0;
      frame_tick    <= 1'b0;
      timeout_flags <= '0;
      late          <= 1'b0;
      overrun       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      vb_q          <= vb;
      frame_tick    <= vb & ~vb_q;
      late          <= ~vb & vb_q & busy;
      state         <= state_n;
      idx           <= idx_n;
      en_q          <= en_q_n;
      timer         <= timer_n;
      req           <= req_n;
      busy          <= busy_n;
      timeout_flags <= flags_n;
      overrun       <= overrun_n;
      frame_cnt     <= frame_cnt_n;
    end
  end

endmodule
